// File: rtl/fill_mem_responder.sv
// Pipelined word memory used as the backing store for cache line fills.
// Accepts one request per cycle; each read returns LATENCY cycles later on data_valid.
module fill_mem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic [3:0]        pending
);

  localparam int WORDS = 1 << (ADDR_W - 1);

  logic [15:0]        mem [WORDS];
  logic [ADDR_W-2:0]  word_idx;
  logic               addr_unused;
  logic               rd_accept;
  logic               rd_exit;
  logic [LATENCY-1:0] valid_reg;
  logic [LATENCY-1:0] valid_next;
  logic [15:0]        data_reg [LATENCY];
  logic [3:0]         pending_reg;
  logic [3:0]         pending_next;

  assign word_idx    = addr[ADDR_W-1:1];
  assign addr_unused = addr[0];
  assign rd_accept   = rst_n & enable & ~wr;
  assign rd_exit     = valid_reg[LATENCY-1];

  // Array and data pipeline carry no reset so the storage maps onto block RAM;
  // the valid bits alone decide whether a stage means anything.
  always_ff @(posedge clk) begin
    if (rst_n && enable && wr)
      mem[word_idx] <= data_in;
    if (enable && !wr)
      data_reg[0] <= mem[word_idx];
    for (int i = 1; i < LATENCY; i++)
      data_reg[i] <= data_reg[i-1];
  end

  assign valid_next[0] = rd_accept;

  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
      assign valid_next[gi] = valid_reg[gi-1];
    end
  endgenerate

  always_comb begin
    pending_next = pending_reg;
    if (rd_accept && !rd_exit)
      pending_next = pending_reg + 4'd1;
    else if (!rd_accept && rd_exit)
      pending_next = pending_reg - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg   <= '0;
      pending_reg <= 4'd0;
    end else begin
      valid_reg   <= valid_next;
      pending_reg <= pending_next;
    end
  end

  assign data_valid = valid_reg[LATENCY-1];
  assign data_out   = data_valid ? data_reg[LATENCY-1] : 16'h0000;
  assign pending    = pending_reg;

endmodule
